// File: rtl/slc3_ctrl_pkg.sv
// Shared types and helpers for the SLC-3 control front-end.
// Auto-repeat state encoding, key polarity and counter width helper.
package slc3_ctrl_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_WAIT_FIRST,
    RPT_REPEATING
  } rpt_state_t;

  localparam logic BTN_RELEASED = 1'b1;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/slc3_button_channel.sv
// One push-button channel: 2-flop synchroniser, debounce filter,
// press/release pulses and an optional auto-repeat pulse train.
module slc3_button_channel
  import slc3_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit REPEAT_ON       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int HW = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic          s1, s2, stable_n;
  logic [CW-1:0] cnt;
  logic          flip, press_flip, release_flip;

  rpt_state_t    state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          rpt_d;

  assign flip         = (s2 != stable_n) && (cnt == DB_LAST);
  assign press_flip   = flip && (s2 != BTN_RELEASED);
  assign release_flip = flip && (s2 == BTN_RELEASED);
  assign level        = (stable_n != BTN_RELEASED);

  // Any synchronised sample that agrees with the accepted level restarts the count.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1            <= BTN_RELEASED;
      s2            <= BTN_RELEASED;
      stable_n      <= BTN_RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn_n;
      s2            <= s1;
      press_pulse   <= press_flip;
      release_pulse <= release_flip;
      if (s2 == stable_n) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable_n <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= RPT_IDLE;
      hc_q         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      repeat_pulse <= rpt_d;
    end
  end

  // A release wins over a repeat falling due on the same edge.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    rpt_d   = 1'b0;
    if (!REPEAT_ON || release_flip) begin
      state_d = RPT_IDLE;
      hc_d    = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (press_flip) begin
            state_d = RPT_WAIT_FIRST;
            hc_d    = '0;
          end
        end
        RPT_WAIT_FIRST: begin
          if (hc_q == DELAY_LAST) begin
            rpt_d   = 1'b1;
            hc_d    = '0;
            state_d = RPT_REPEATING;
          end else begin
            hc_d = hc_q + HW'(1);
          end
        end
        RPT_REPEATING: begin
          if (hc_q == PERIOD_LAST) begin
            rpt_d = 1'b1;
            hc_d  = '0;
          end else begin
            hc_d = hc_q + HW'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          hc_d    = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/slc3_button_conditioner.sv
// Conditions NUM_BTN raw active-low board keys into debounced levels,
// press/release pulses and per-channel optional auto-repeat pulses.
module slc3_button_conditioner
  import slc3_ctrl_pkg::*;
#(
  parameter int                 NUM_BTN         = 2,
  parameter int                 DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_BTN-1:0] REPEAT_EN       = '0,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_BTN-1:0] btn_n_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] repeat_o
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    slc3_button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_ON      (REPEAT_EN[i]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .btn_n        (btn_n_i[i]),
      .level        (level_o[i]),
      .press_pulse  (press_o[i]),
      .release_pulse(release_o[i]),
      .repeat_pulse (repeat_o[i])
    );
  end

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Self-checking bench for slc3_button_conditioner: directed scenarios with
// literal expectations plus randomized keys checked by a window-based model.
module tb_slc3_button_conditioner;

  localparam int         NB  = 2;
  localparam int         DB  = 4;
  localparam logic [1:0] REN = 2'b10;
  localparam int         RD  = 8;
  localparam int         RP  = 3;

  logic          Clk;
  logic          Reset_n;
  logic [NB-1:0] btn_n_i;
  logic [NB-1:0] level_o, press_o, release_o, repeat_o;

  int total = 0;
  int bad   = 0;

  slc3_button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN      (REN),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .btn_n_i  (btn_n_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .repeat_o (repeat_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: hist[ch][k] is the raw key sampled k edges ago. A change is accepted
  // when the DB synchronised samples (raw from 2..DB+1 edges ago) all disagree
  // with the accepted level. Repeats follow from the press edge arithmetically.
  int         edgeNum = 0;
  bit         modelValid = 1'b0;
  bit         hist [NB][DB+2];
  bit         mStable [NB];
  bit         held [NB];
  int         pressEdge [NB];
  bit         allOpp;
  logic [1:0] mLevel, mPress, mRel, mRpt;

  always @(posedge Clk) begin
    edgeNum++;
    mPress = '0;
    mRel   = '0;
    mRpt   = '0;
    if (!Reset_n) begin
      for (int ch = 0; ch < NB; ch++) begin
        for (int j = 0; j < DB + 2; j++) hist[ch][j] = 1'b1;
        mStable[ch]   = 1'b1;
        held[ch]      = 1'b0;
        pressEdge[ch] = 0;
      end
      modelValid = 1'b1;
    end else begin
      for (int ch = 0; ch < NB; ch++) begin
        for (int j = DB + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = btn_n_i[ch];
        allOpp = 1'b1;
        for (int j = 2; j < DB + 2; j++)
          if (hist[ch][j] == mStable[ch]) allOpp = 1'b0;
        if (allOpp) begin
          mStable[ch] = ~mStable[ch];
          if (!mStable[ch]) begin
            mPress[ch]    = 1'b1;
            held[ch]      = 1'b1;
            pressEdge[ch] = edgeNum;
          end else begin
            mRel[ch] = 1'b1;
            held[ch] = 1'b0;
          end
        end
        if (REN[ch] && held[ch] && (edgeNum - pressEdge[ch]) >= RD &&
            ((edgeNum - pressEdge[ch] - RD) % RP) == 0)
          mRpt[ch] = 1'b1;
      end
    end
    for (int ch = 0; ch < NB; ch++) mLevel[ch] = ~mStable[ch];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] keys);
    btn_n_i = keys;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic waitUntilEdge(input int target);
    while (edgeNum < target) @(negedge Clk);
  endtask

  task automatic pulseReset();
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge Clk) begin
    if (modelValid) begin
      checkOutput("model_level",   level_o,   mLevel);
      checkOutput("model_press",   press_o,   mPress);
      checkOutput("model_release", release_o, mRel);
      checkOutput("model_repeat",  repeat_o,  mRpt);
    end
  end

  int e, p, r, seen;

  initial begin
    Reset_n = 1'b0;
    btn_n_i = 2'b11;
    waitCycles(3);
    checkOutput("reset_level",  level_o,   2'b00);
    checkOutput("reset_press",  press_o,   2'b00);
    checkOutput("reset_repeat", repeat_o,  2'b00);
    Reset_n = 1'b1;
    waitCycles(5);

    $display("[TB] clean press on channel 0");
    applyStimulus(2'b10);
    e = edgeNum + 1;
    waitUntilEdge(e + 4);
    checkOutput("press0_early", press_o, 2'b00);
    checkOutput("level0_early", level_o, 2'b00);
    waitUntilEdge(e + 5);
    checkOutput("press0_fire", press_o, 2'b01);
    checkOutput("level0_fire", level_o, 2'b01);
    waitUntilEdge(e + 6);
    checkOutput("press0_once", press_o, 2'b00);
    seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (repeat_o[0]) seen++;
    end
    checkOutput("repeat0_never", seen, 0);

    $display("[TB] release on channel 0");
    applyStimulus(2'b11);
    e = edgeNum + 1;
    waitUntilEdge(e + 4);
    checkOutput("release0_early", release_o, 2'b00);
    waitUntilEdge(e + 5);
    checkOutput("release0_fire", release_o, 2'b01);
    checkOutput("level0_off",    level_o,   2'b00);
    waitUntilEdge(e + 6);
    checkOutput("release0_once", release_o, 2'b00);

    $display("[TB] bounce rejection on channel 0");
    seen = 0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int c = 0; c < 6; c++) begin
        applyStimulus((c < 3) ? 2'b10 : 2'b11);
        @(negedge Clk);
        if (level_o[0] || press_o[0] || release_o[0]) seen++;
      end
    end
    repeat (8) begin
      @(negedge Clk);
      if (level_o[0] || press_o[0] || release_o[0]) seen++;
    end
    checkOutput("bounce_ignored", seen, 0);

    $display("[TB] auto-repeat on channel 1");
    applyStimulus(2'b01);
    e = edgeNum + 1;
    p = e + 5;
    waitUntilEdge(p);
    checkOutput("press1_fire", press_o, 2'b10);
    waitUntilEdge(p + 7);
    checkOutput("rpt_before_delay", repeat_o, 2'b00);
    waitUntilEdge(p + 8);
    checkOutput("rpt_first", repeat_o, 2'b10);
    waitUntilEdge(p + 9);
    checkOutput("rpt_gap", repeat_o, 2'b00);
    waitUntilEdge(p + 11);
    checkOutput("rpt_second", repeat_o, 2'b10);
    applyStimulus(2'b11);
    waitUntilEdge(p + 14);
    checkOutput("rpt_third", repeat_o, 2'b10);
    waitUntilEdge(p + 16);
    checkOutput("release1_early", release_o, 2'b00);
    waitUntilEdge(p + 17);
    checkOutput("release1_fire",      release_o, 2'b10);
    checkOutput("rpt_blocked_by_rel", repeat_o,  2'b00);
    waitUntilEdge(p + 20);
    checkOutput("rpt_stopped", repeat_o, 2'b00);

    $display("[TB] reset while channel 1 repeats");
    waitCycles(6);
    applyStimulus(2'b01);
    e = edgeNum + 1;
    p = e + 5;
    waitUntilEdge(p + 10);
    Reset_n = 1'b0;
    r = edgeNum + 1;
    waitUntilEdge(r);
    Reset_n = 1'b1;
    checkOutput("rst_level",  level_o,   2'b00);
    checkOutput("rst_press",  press_o,   2'b00);
    checkOutput("rst_repeat", repeat_o,  2'b00);
    waitUntilEdge(r + 5);
    checkOutput("repress_early", press_o, 2'b00);
    waitUntilEdge(r + 6);
    checkOutput("repress_fire", press_o, 2'b10);
    checkOutput("relevel_fire", level_o, 2'b10);
    waitUntilEdge(r + 13);
    checkOutput("rerpt_early", repeat_o, 2'b00);
    waitUntilEdge(r + 14);
    checkOutput("rerpt_first", repeat_o, 2'b10);

    $display("[TB] simultaneous press and release");
    applyStimulus(2'b11);
    waitCycles(10);
    applyStimulus(2'b00);
    e = edgeNum + 1;
    waitUntilEdge(e + 5);
    checkOutput("press_both", press_o, 2'b11);
    checkOutput("level_both", level_o, 2'b11);
    applyStimulus(2'b11);
    e = edgeNum + 1;
    waitUntilEdge(e + 5);
    checkOutput("release_both", release_o, 2'b11);

    $display("[TB] randomized key activity");
    repeat (250) begin
      applyStimulus(NB'($urandom_range(0, 3)));
      if ($urandom_range(0, 40) == 0) pulseReset();
      waitCycles($urandom_range(1, 30));
    end

    applyStimulus(2'b11);
    waitCycles(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slc3_button_conditioner.md
Name: slc3_button_conditioner

Overview:
Parametrised front-end for the SLC-3 push-button controls such as Run, Continue and Reset keys. It turns N raw active-low board keys into clean, synchronised, debounced levels. It also produces single-cycle press and release pulses, plus an optional per-channel auto-repeat pulse train. It sits between the board KEY pins and the slc3 control/ISDU logic, and replaces ad-hoc per-button synchronisers.

Parameters:
NUM_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a change (>=1)
REPEAT_EN, '0, NUM_BTN-bit mask; bit i=1 enables auto-repeat on channel i
REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset_n  input  1  synchronous active-low reset
btn_n_i  input  NUM_BTN  raw asynchronous keys, 0 = pressed
level_o  output  NUM_BTN  debounced level, 1 = pressed
press_o  output  NUM_BTN  one-cycle pulse on accepted press
release_o  output  NUM_BTN  one-cycle pulse on accepted release
repeat_o  output  NUM_BTN  one-cycle auto-repeat pulse (REPEAT_EN channels only)

Behaviour:
- Reset: one clock, synchronous active-low reset.
  - Reset_n=0 sampled at an edge sets sync flops to 1 (released), stable=released, all counters 0, and level_o/press_o/release_o/repeat_o=0.
  - This applies mid-debounce or mid-repeat: any pending event is discarded.
- Synchroniser: 2-flop per channel (s1<=btn_n_i, s2<=s1). There is no combinational path from btn_n_i to any output.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - At each edge, if s2==stable_n, cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1, then stable_n<=s2 and cnt<=0.
  - Otherwise cnt<=cnt+1.
  - Any sample that agrees with stable_n restarts the count, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: a raw change first sampled by s1 at edge k updates level_o at edge k+1+DEBOUNCE_CYCLES.
- press_o/release_o:
  - Registered and asserted for exactly the one cycle following the flip edge.
  - press_o for a flip to pressed, release_o for a flip to released.
  - Never both in the same cycle on one channel.
- Auto-repeat FSM, per channel, states IDLE, WAIT_FIRST, REPEATING:
  - IDLE -> WAIT_FIRST on the press flip, with hold counter hc<=0.
  - WAIT_FIRST: hc increments each edge. When hc==REPEAT_DELAY-1: assert repeat_o next cycle, hc<=0, go to REPEATING.
  - REPEATING: when hc==REPEAT_PERIOD-1: assert repeat_o, hc<=0.
  - Any state -> IDLE on the release flip. Release takes precedence over a repeat due in the same edge, so no repeat_o is emitted.
  - If REPEAT_EN[i]=0, the FSM is held in IDLE and repeat_o[i] is constantly 0.
- Repeat timing: the press flip at edge P gives repeat_o in the cycles after edges P+REPEAT_DELAY, then P+REPEAT_DELAY+n*REPEAT_PERIOD. The counter never overflows.
- Key held at reset release: sees s2=0 vs stable released, debounces normally, and produces press_o DEBOUNCE_CYCLES+1 edges after reset deassert plus sync latency.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Package slc3_ctrl_pkg holds:
  - typedef enum logic [1:0] {RPT_IDLE, RPT_WAIT_FIRST, RPT_REPEATING} rpt_state_t;
  - the constant BTN_RELEASED=1'b1;
  - function clog2_min1 for counter widths.
- One sub-module, slc3_button_channel, implements a single channel: sync, debounce, pulse and repeat FSM. It takes scalar ports plus a REPEAT_ON parameter.
- The top generates NUM_BTN instances, indexing REPEAT_EN[i].

Test Plan:
All scenarios use NUM_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_EN=2'b10, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Clean press: btn_n_i[0] 1->0, first sampled at edge 10 -> level_o[0]=1 and press_o[0]=1 after edge 15 for exactly one cycle; repeat_o[0] stays 0 while held for 40 cycles.
- Bounce reject: btn_n_i[0] low for 3 cycles then high, repeated 5 times -> level_o, press_o and release_o all stay 0.
- Release: after the clean press, btn_n_i[0] ->1 sampled at edge 60 -> level_o[0]=0 and release_o[0]=1 after edge 65 for one cycle.
- Auto-repeat: channel 1 press flip at edge P, held 30 cycles -> repeat_o[1] pulses after edges P+8, P+11, P+14, P+17, and so on; release stops pulses, with no repeat in the release cycle.
- Reset mid-operation: channel 1 in REPEATING, Reset_n=0 for 1 edge while the key stays pressed -> all outputs 0 next cycle; press_o[1] re-fires 4 debounce edges after sync refill; first repeat comes 8 cycles after that press.
- Simultaneous: both keys pressed in the same cycle -> press_o=2'b11 in the same cycle; level_o=2'b11.
